// File: rtl/alici_verici_denetleyici.sv
// alici_verici_denetleyici
// Arbitrates a shared serial link between two transmit requesters (TX0, TX1)
// and one receive requester (RX). A granted transmit word is shifted out
// LSB-first on tx. A receive frame shifts WIDTH bits from rx into rx_data.
//
// Ports:
//   clk, rst             system clock, async active-high reset
//   tx_req0/tx_data0     TX0 request (level) and word, sampled at grant
//   tx_req1/tx_data1     TX1 request (level) and word, sampled at grant
//   rx_req, rx           RX request (level) and serial input, LSB first
//   tx, tx_en            serial output and transmit frame strobe
//   rx_en                receive frame strobe
//   tx_ack0/1, rx_valid  one-cycle end-of-frame pulses
//   rx_data              last received word
//   busy                 high while a frame is in progress
//   frame_cnt            completed frames, wraps at 256
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | link free; arbitrate unless an ack/rx_valid is high (gap)
// TX    | shifting r_sh out on tx, r_cnt = index of the bit on tx
// RX    | sampling rx into r_sh[r_cnt]
module alici_verici_denetleyici #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_req0,
    input  logic [WIDTH-1:0] tx_data0,
    input  logic             tx_req1,
    input  logic [WIDTH-1:0] tx_data1,
    input  logic             rx_req,
    input  logic             rx,
    output logic             tx,
    output logic             tx_en,
    output logic             rx_en,
    output logic             tx_ack0,
    output logic             tx_ack1,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TX   = 2'd1;
    localparam logic [1:0] S_RX   = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh;
    logic             r_last_tx;
    logic             r_last_rx;
    logic             r_tx;
    logic             r_tx_en;
    logic             r_rx_en;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_rx_valid;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_busy;
    logic [7:0]       r_frame_cnt;

    logic             w_gap;
    logic             w_any_tx;
    logic             w_idle_ok;
    logic             w_grant_rx;
    logic             w_grant_tx;
    logic             w_win;
    logic [WIDTH-1:0] w_win_data;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_last_bit;

    // The end-of-frame pulse cycle doubles as the mandatory idle gap.
    assign w_gap      = r_ack0 | r_ack1 | r_rx_valid;
    assign w_any_tx   = tx_req0 | tx_req1;
    assign w_idle_ok  = (r_state == S_IDLE) && !w_gap;
    // RX yields once to pending TX right after it was served (anti-starvation).
    assign w_grant_rx = w_idle_ok && rx_req && !(r_last_rx && w_any_tx);
    assign w_grant_tx = w_idle_ok && !w_grant_rx && w_any_tx;
    assign w_win      = (tx_req0 && tx_req1) ? ~r_last_tx : tx_req1;
    assign w_win_data = w_win ? tx_data1 : tx_data0;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_last_bit = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_last_tx   <= 1'b1;
            r_last_rx   <= 1'b0;
            r_tx        <= 1'b0;
            r_tx_en     <= 1'b0;
            r_rx_en     <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_busy      <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_rx) begin
                        r_state   <= S_RX;
                        r_cnt     <= '0;
                        r_rx_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_last_rx <= 1'b1;
                    end else if (w_grant_tx) begin
                        r_state   <= S_TX;
                        r_sh      <= w_win_data;
                        r_cnt     <= '0;
                        r_tx      <= w_win_data[0];
                        r_tx_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_last_tx <= w_win;
                        r_last_rx <= 1'b0;
                    end
                end
                S_TX: begin
                    if (w_last_bit) begin
                        r_state     <= S_IDLE;
                        r_tx        <= 1'b0;
                        r_tx_en     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ack0      <= ~r_last_tx;
                        r_ack1      <= r_last_tx;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        r_tx  <= r_sh[w_cnt_inc];
                    end
                end
                S_RX: begin
                    r_sh[r_cnt] <= rx;
                    if (w_last_bit) begin
                        r_state     <= S_IDLE;
                        // Final bit goes straight to rx_data; r_sh only holds the lower bits yet.
                        r_rx_data   <= {rx, r_sh[WIDTH-2:0]};
                        r_rx_valid  <= 1'b1;
                        r_rx_en     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx        = r_tx;
    assign tx_en     = r_tx_en;
    assign rx_en     = r_rx_en;
    assign tx_ack0   = r_ack0;
    assign tx_ack1   = r_ack1;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_alici_verici_denetleyici.sv
// Directed testbench for alici_verici_denetleyici (WIDTH = 3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alici_verici_denetleyici;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_req0, tx_req1, rx_req, rx;
    logic [W-1:0] tx_data0, tx_data1;
    logic         tx, tx_en, rx_en, tx_ack0, tx_ack1, rx_valid, busy;
    logic [W-1:0] rx_data;
    logic [7:0]   frame_cnt;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           acks;
    logic [W-1:0] d;
    logic [W-1:0] rb;
    logic         w;
    logic         isrx;

    always #5 clk = ~clk;

    alici_verici_denetleyici #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_req0   (tx_req0),
        .tx_data0  (tx_data0),
        .tx_req1   (tx_req1),
        .tx_data1  (tx_data1),
        .rx_req    (rx_req),
        .rx        (rx),
        .tx        (tx),
        .tx_en     (tx_en),
        .rx_en     (rx_en),
        .tx_ack0   (tx_ack0),
        .tx_ack1   (tx_ack1),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tx_req0 = 1'b0; tx_req1 = 1'b0; rx_req = 1'b0; rx = 1'b0;
        tx_data0 = '0; tx_data1 = '0;
        @(negedge clk); @(negedge clk);

        // reset state
        chk("rst_tx", tx, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_rx_en", rx_en, 0);
        chk("rst_ack0", tx_ack0, 0);
        chk("rst_ack1", tx_ack1, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // single TX0 frame, data 101
        rst = 1'b0; tx_req0 = 1'b1; tx_data0 = 3'b101; d = 3'b101;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("t1_tx", tx, d[k]);
            chk("t1_tx_en", tx_en, 1);
            chk("t1_busy", busy, 1);
        end
        @(negedge clk);
        chk("t1_ack0", tx_ack0, 1);
        chk("t1_tx_en_off", tx_en, 0);
        chk("t1_tx_off", tx, 0);
        chk("t1_frame_cnt", frame_cnt, 1);
        tx_req0 = 1'b0;
        @(negedge clk);
        chk("t1_ack0_pulse", tx_ack0, 0);
        chk("t1_idle_busy", busy, 0);

        // both TX requesters held: TX0, TX1, TX0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_req0 = 1'b1; tx_req1 = 1'b1;
        tx_data0 = 3'b011; tx_data1 = 3'b110;
        for (int f = 0; f < 3; f++) begin
            w = (f % 2) == 1;
            d = w ? 3'b110 : 3'b011;
            for (int k = 0; k < W; k++) begin
                @(negedge clk);
                chk("t2_tx", tx, d[k]);
                chk("t2_tx_en", tx_en, 1);
            end
            @(negedge clk);
            chk("t2_ack0", tx_ack0, !w);
            chk("t2_ack1", tx_ack1, w);
            chk("t2_frame_cnt", frame_cnt, f + 1);
            chk("t2_tx_en_off", tx_en, 0);
            if (f == 2) begin
                tx_req0 = 1'b0; tx_req1 = 1'b0;
            end
            @(negedge clk);
            chk("t2_gap_tx_en", tx_en, 0);
        end

        // RX frame: 1,1,0 -> 011
        rx_req = 1'b1; rb = 3'b011;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("t3_rx_en", rx_en, 1);
            rx = rb[k];
        end
        @(negedge clk);
        chk("t3_rx_valid", rx_valid, 1);
        chk("t3_rx_data", rx_data, 3'b011);
        chk("t3_rx_en_off", rx_en, 0);
        chk("t3_frame_cnt", frame_cnt, 4);
        rx_req = 1'b0; rx = 1'b0;
        @(negedge clk);
        chk("t3_rx_valid_pulse", rx_valid, 0);
        chk("t3_rx_data_hold", rx_data, 3'b011);
        @(negedge clk);
        chk("t3_rx_data_hold2", rx_data, 3'b011);

        // RX and TX1 held: RX, TX1, RX, TX1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rx_req = 1'b1; tx_req1 = 1'b1; tx_data1 = 3'b110; rx = 1'b1;
        d = 3'b110;
        for (int f = 0; f < 4; f++) begin
            isrx = (f % 2) == 0;
            for (int k = 0; k < W; k++) begin
                @(negedge clk);
                chk("t4_rx_en", rx_en, isrx);
                chk("t4_tx_en", tx_en, !isrx);
                chk("t4_tx", tx, isrx ? 1'b0 : d[k]);
            end
            @(negedge clk);
            chk("t4_rx_valid", rx_valid, isrx);
            chk("t4_ack1", tx_ack1, !isrx);
            chk("t4_frame_cnt", frame_cnt, f + 1);
            if (f == 3) begin
                rx_req = 1'b0; tx_req1 = 1'b0; rx = 1'b0;
            end
            @(negedge clk);
            chk("t4_gap_busy", busy, 0);
        end
        chk("t4_rx_data", rx_data, 3'b111);

        // reset during second bit of an RX frame
        rx_req = 1'b1;
        @(negedge clk);
        chk("t5_rx_en_b0", rx_en, 1);
        rx = 1'b1;
        @(negedge clk);
        chk("t5_rx_en_b1", rx_en, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_rx_en", rx_en, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rx_data", rx_data, 0);
        chk("t5_rst_frame_cnt", frame_cnt, 0);
        chk("t5_rst_rx_valid", rx_valid, 0);
        rx_req = 1'b0; rx = 1'b0;
        @(negedge clk);
        chk("t5_no_rx_valid", rx_valid, 0);
        rst = 1'b0; rx_req = 1'b1; rb = 3'b110;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("t5_rx_en", rx_en, 1);
            rx = rb[k];
        end
        @(negedge clk);
        chk("t5_rx_valid", rx_valid, 1);
        chk("t5_rx_data", rx_data, 3'b110);
        chk("t5_frame_cnt", frame_cnt, 1);
        rx_req = 1'b0; rx = 1'b0;
        @(negedge clk);

        // 256 back-to-back TX0 frames: frame_cnt wraps
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_req0 = 1'b1; tx_data0 = 3'b101; acks = 0;
        for (int f = 0; f < 256; f++) begin
            for (int c = 0; c < W + 2; c++) begin
                @(negedge clk);
                if (tx_ack0) acks++;
                if (c == W) begin
                    if (f == 254) chk("t6_frame_cnt_255", frame_cnt, 255);
                    if (f == 255) begin
                        chk("t6_frame_cnt_wrap", frame_cnt, 0);
                        tx_req0 = 1'b0;
                    end
                end
            end
        end
        chk("t6_ack0_count", acks, 256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
